// File: rtl/add_pipe_pkg.sv
// Shared types and constants for the add_pipe adder/subtractor slice.
package add_pipe_pkg;

    // Operation select carried on in_op.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    // Upper bound on the pipeline depth the top is built for.
    localparam int unsigned MAX_STAGES = 4;

    // Width of the optional completed-transaction counter.
    localparam int unsigned TXN_CNT_W = 16;

endpackage

// File: rtl/add_pipe_stage.sv
// One valid/ready register slice of the add_pipe pipeline.
// Holds a payload and its valid bit. It refills whenever it is empty or its
// contents are leaving this cycle, so a full chain streams without bubbles.
module add_pipe_stage
    import add_pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [PAYLOAD_W-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PAYLOAD_W-1:0] m_data_o
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;

    // Slot can take new data when empty or when its occupant is leaving.
    assign s_ready_o = !valid_q || m_ready_i;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;

    // Next state: load on upstream transfer, drain to empty otherwise; data is
    // only overwritten by a real transfer so the output holds after a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_ready_o) begin
            valid_d = s_valid_i;
            if (s_valid_i) begin
                data_d = s_data_i;
            end
        end
    end

    // Slot registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/add_pipe.sv
// Pipelined, back-pressurable adder/subtractor with tag passthrough.
// Arithmetic is combinational ahead of stage 0; the remaining stages delay
// result and tag. Define ADD_PIPE_CNT_EN to add the txn_cnt output and its
// 16-bit wrapping counter of completed output handshakes.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_c,
    output logic [TAG_W-1:0] out_tag
`ifdef ADD_PIPE_CNT_EN
    ,
    output logic [TXN_CNT_W-1:0] txn_cnt
`endif
);

    localparam int unsigned PAYLOAD_W = WIDTH + 1 + TAG_W;

    // Handshake chain: index k is the input side of stage k, index STAGES is
    // the block output.
    logic [STAGES:0]       vld;
    logic [STAGES:0]       rdy;
    logic [PAYLOAD_W-1:0]  pay [0:STAGES];

    add_op_e               op;
    logic [WIDTH:0]        result;

    assign op = add_op_e'(in_op);

    // Add or subtract in WIDTH+1 bits; the top bit is carry or borrow.
    always_comb begin
        result = {1'b0, in_a} + {1'b0, in_b};
        if (op == OP_SUB) begin
            result = {1'b0, in_a} - {1'b0, in_b};
        end
    end

    assign vld[0]      = in_valid;
    assign pay[0]      = {result, in_tag};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    assign out_valid   = vld[STAGES];
    assign {out_c, out_tag} = pay[STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            add_pipe_stage #(
                .PAYLOAD_W (PAYLOAD_W)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .s_valid_i (vld[gi]),
                .s_ready_o (rdy[gi]),
                .s_data_i  (pay[gi]),
                .m_valid_o (vld[gi+1]),
                .m_ready_i (rdy[gi+1]),
                .m_data_o  (pay[gi+1])
            );
        end
    endgenerate

`ifdef ADD_PIPE_CNT_EN
    logic [TXN_CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d   = (out_valid && out_ready) ? cnt_q + 1'b1 : cnt_q;
    assign txn_cnt = cnt_q;

    // Count completed output handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined, back-pressurable adder/subtractor with per-transaction tag passthrough. It replaces the fixed 8-bit single-cycle registered adder in the datapath and is the arithmetic element behind the UVM add bench. Each accepted operand pair is added or subtracted and emitted STAGES cycles later, with its tag, over a valid/ready handshake. Throughput is one result per cycle.

## Interface
- WIDTH, 8: operand width in bits; WIDTH ≥ 1.
- STAGES, 2: pipeline register stages, 1..4; 1 gives the legacy single-cycle latency.
- TAG_W, 4: width of the sideband tag (channel/transaction ID); TAG_W ≥ 1.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts the pair this cycle.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_op  input  1  0 = add, 1 = subtract (A − B).
- in_tag  input  TAG_W  tag carried unchanged to the output.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts the result.
- out_c  output  WIDTH+1  result.
- out_tag  output  TAG_W  tag of the presented result.
- txn_cnt  output  16  completed output handshakes; present only with ADD_PIPE_CNT_EN.

## Operation
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Add: out_c = {0,A} + {0,B}; bit WIDTH is the carry.
- Sub: out_c = ({0,A} − {0,B}) mod 2^(WIDTH+1); bit WIDTH = 1 indicates borrow (A < B). Low WIDTH bits are the two's-complement difference.
- Arithmetic is computed combinationally into stage 0. Stages 1..STAGES−1 are pure delay registers for result and tag.
- Each stage k holds {v[k], c[k], tag[k]}. The stage advances when the next stage is empty or is itself advancing. The last stage advances on an output handshake.
- in_ready = !v[0] || advance[0]. There is no combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready through the ready chain.
- A stalled stage holds its data and valid unchanged.
- out_c and out_tag always show the last-stage register. After an output handshake with no new data, they keep their last value while out_valid = 0, matching legacy hold behaviour.
- The block never drops or duplicates a transaction. Order is preserved.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - all v[k] = 0, all data and tag registers = 0;
  - out_valid = 0, out_c = 0, out_tag = 0, txn_cnt = 0;
  - in_ready = 1 while rst_n is high and the pipeline is empty.
- Latency: an input accepted at edge N gives out_valid = 1 after edge N+STAGES−1, i.e. visible in the cycle following edge N+STAGES−1. With STAGES = 1, the result is visible the cycle after acceptance.
- Full pipeline with out_ready = 0: all STAGES slots hold data and in_ready = 0 in the same cycle.
- Full pipeline, out_ready = 1, in_valid = 1: a simultaneous output and input transfer happens every cycle with no bubble.
- Reset mid-operation: all in-flight transactions are discarded immediately. txn_cnt returns to 0.
- in_op, in_a, in_b and in_tag are sampled only on an input handshake.

## Configuration
- ADD_PIPE_CNT_EN defined: the txn_cnt port and a 16-bit counter exist. The counter increments by 1 on each output handshake and wraps from 0xFFFF to 0x0000.
- Not defined: no port and no counter. All other behaviour is identical.

## Structure
- Package add_pipe_pkg:
  - typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;
  - localparam int unsigned MAX_STAGES = 4;
  - localparam int unsigned TXN_CNT_W = 16.
- Sub-module add_pipe_stage (WIDTH+1+TAG_W payload, valid/ready register slice). The top instantiates STAGES copies in a generate loop and places the add/sub logic ahead of stage 0.

## Test plan
- Reset: hold rst_n = 0, drive in_valid = 1 → out_valid = 0, out_c = 0, out_tag = 0; after release, in_ready = 1.
- Add: WIDTH = 8, STAGES = 2, A = 0xFF, B = 0x01, op = 0, tag = 3 → out_c = 0x100, out_tag = 3, out_valid exactly 2 cycles after acceptance.
- Subtract: A = 0x05, B = 0x07, op = 1 → out_c = 0x1FE (borrow set). Then A = 0x07, B = 0x05 → out_c = 0x002.
- Back-pressure: stream tags 0..9 with out_ready = 0 for 6 cycles → in_ready falls after 2 accepts; after release, tags appear in order 0..9, none lost or duplicated, results held stable during the stall.
- Full throughput: in_valid = out_ready = 1 for 100 random pairs → 100 results on consecutive cycles, all matching the model. With ADD_PIPE_CNT_EN, txn_cnt = 100.
- Mid-stream reset: assert rst_n with 2 in flight → out_valid = 0 immediately, no stale result after release, txn_cnt = 0.
